// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control unit for the 8-bit CPU.
// A Moore FSM steps each instruction through fetch, decode and execute states.
// The same block holds the architectural flag register and checks each
// instruction's condition field against it.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   Instr[15:0]     instruction: {Cond[3:0], Op[1:0], I, Cmd[2:0], S/L, imm[4:0]}
//   ALUFlags[3:0]   {CO,OVF,N,Z} from the ALU, loaded into Flags in EXECR/EXECI
//   PCWrite, IRWrite, MemWrite, RegWrite   write strobes; held low while rst_n=0
//   AdrSrc          memory address select: 0 = PC, 1 = ALUOut
//   ResultSrc[1:0]  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA         ALU A operand: 0 = RegA, 1 = PC
//   ALUSrcB[1:0]    ALU B operand: 00 = RegB, 01 = ExtImm, 10 = constant 1
//   ALUOp           1 = use ALUControl, 0 = pass SrcB
//   ALUControl[2:0] ALU operation code
//   ImmSrc[1:0]     Instr[11:10], passed straight through
//   Flags[3:0]      flag register {C,V,N,Z}
//   State[3:0]      current state encoding, for debug

module mc_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        ALUOp,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  Flags,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9
    } state_e;

    localparam logic [2:0] CmdCmp = 3'b110;
    localparam logic [2:0] CmdMov = 3'b111;

    state_e     r_state;
    state_e     w_state_next;
    logic [3:0] r_flags;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic       w_imm;
    logic [2:0] w_cmd;
    logic       w_sl;
    logic       w_cond_ok;
    logic       w_flag_load;

    logic       w_flag_c, w_flag_v, w_flag_n, w_flag_z;
    logic       w_pcwrite, w_irwrite, w_memwrite, w_regwrite;
    logic       w_dp_aluop;
    logic [2:0] w_dp_alucontrol;

    assign w_cond = Instr[15:12];
    assign w_op   = Instr[11:10];
    assign w_imm  = Instr[9];
    assign w_cmd  = Instr[8:6];
    assign w_sl   = Instr[5];

    assign {w_flag_c, w_flag_v, w_flag_n, w_flag_z} = r_flags;

    // Condition check against the registered flags.
    always_comb begin
        w_cond_ok = 1'b0;
        case (w_cond)
            4'h0:    w_cond_ok = w_flag_z;
            4'h1:    w_cond_ok = !w_flag_z;
            4'h2:    w_cond_ok = w_flag_c;
            4'h3:    w_cond_ok = !w_flag_c;
            4'h4:    w_cond_ok = w_flag_n;
            4'h5:    w_cond_ok = !w_flag_n;
            4'h6:    w_cond_ok = w_flag_v;
            4'h7:    w_cond_ok = !w_flag_v;
            4'h8:    w_cond_ok = w_flag_c && !w_flag_z;
            4'h9:    w_cond_ok = !w_flag_c || w_flag_z;
            4'hA:    w_cond_ok = (w_flag_n == w_flag_v);
            4'hB:    w_cond_ok = (w_flag_n != w_flag_v);
            4'hC:    w_cond_ok = !w_flag_z && (w_flag_n == w_flag_v);
            4'hD:    w_cond_ok = w_flag_z || (w_flag_n != w_flag_v);
            4'hE:    w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // Data-processing ALU controls: CMP subtracts, MOV passes SrcB through.
    always_comb begin
        w_dp_aluop      = 1'b1;
        w_dp_alucontrol = w_cmd;
        if (w_cmd == CmdCmp) begin
            w_dp_alucontrol = 3'b001;
        end else if (w_cmd == CmdMov) begin
            w_dp_aluop      = 1'b0;
            w_dp_alucontrol = 3'b000;
        end
    end

    // CMP always updates flags, whatever its S bit says.
    assign w_flag_load = ((r_state == StExecR) || (r_state == StExecI)) &&
                         (w_sl || (w_cmd == CmdCmp));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_state_next;
            if (w_flag_load) begin
                r_flags <= ALUFlags;
            end
        end
    end

    always_comb begin
        w_state_next = StFetch;
        case (r_state)
            StFetch:  w_state_next = StDecode;
            StDecode: begin
                if (!w_cond_ok || (w_op == 2'b11)) begin
                    w_state_next = StFetch;
                end else if (w_op == 2'b00) begin
                    w_state_next = w_imm ? StExecI : StExecR;
                end else if (w_op == 2'b01) begin
                    w_state_next = StMemAdr;
                end else begin
                    w_state_next = StBranch;
                end
            end
            StMemAdr: w_state_next = w_sl ? StMemRd : StMemWr;
            StMemRd:  w_state_next = StMemWb;
            StExecR,
            StExecI:  w_state_next = (w_cmd == CmdCmp) ? StFetch : StAluWb;
            default:  w_state_next = StFetch;
        endcase
    end

    always_comb begin
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 1'b0;
        ALUControl = 3'b000;
        case (r_state)
            StFetch: begin
                w_irwrite  = 1'b1;
                w_pcwrite  = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 1'b1;
                ResultSrc  = 2'b10;
            end
            StDecode: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = 1'b1;
            end
            StMemAdr: begin
                ALUSrcB    = 2'b01;
                ALUOp      = 1'b1;
            end
            StMemRd: begin
                AdrSrc     = 1'b1;
            end
            StMemWb: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            StMemWr: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            StExecR: begin
                ALUOp      = w_dp_aluop;
                ALUControl = w_dp_alucontrol;
            end
            StExecI: begin
                ALUSrcB    = 2'b01;
                ALUOp      = w_dp_aluop;
                ALUControl = w_dp_alucontrol;
            end
            StAluWb: begin
                w_regwrite = 1'b1;
            end
            StBranch: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUOp      = 1'b1;
                ResultSrc  = 2'b10;
                w_pcwrite  = 1'b1;
            end
            default: ;
        endcase
    end

    // The async reset sends the state to FETCH at once, which would raise the
    // FETCH strobes. Gate them with rst_n so nothing writes while reset is held.
    assign PCWrite  = w_pcwrite  & rst_n;
    assign IRWrite  = w_irwrite  & rst_n;
    assign MemWrite = w_memwrite & rst_n;
    assign RegWrite = w_regwrite & rst_n;

    assign ImmSrc = w_op;
    assign Flags  = r_flags;
    assign State  = r_state;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUOp;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  Flags, State;

    int checks   = 0;
    int failures = 0;
    logic [3:0] m_flags;

    mc_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .Flags      (Flags),
        .State      (State)
    );

    always #5 clk = ~clk;

    // Condition predicate on flags {C,V,N,Z}.
    function automatic bit cond_true(input logic [3:0] cond, input logic [3:0] f);
        bit c, v, n, z;
        c = f[3]; v = f[2]; n = f[1]; z = f[0];
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected outputs packed as
    // {PCWrite,IRWrite,MemWrite,RegWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ALUControl}.
    function automatic logic [13:0] exp_out(input int st, input logic [15:0] ins);
        logic pcw, irw, mw, rw, adr, srca, op;
        logic [1:0] rs, srcb;
        logic [2:0] ctl, cmd;
        pcw = 0; irw = 0; mw = 0; rw = 0; adr = 0; srca = 0; op = 0;
        rs = 0; srcb = 0; ctl = 0;
        cmd = ins[8:6];
        case (st)
            0: begin irw = 1; pcw = 1; srca = 1; srcb = 2; op = 1; rs = 2; end
            1: begin srca = 1; srcb = 2; op = 1; end
            2: begin srcb = 1; op = 1; end
            3: adr = 1;
            4: begin rs = 1; rw = 1; end
            5: begin adr = 1; mw = 1; end
            6, 7: begin
                srcb = (st == 7) ? 2'd1 : 2'd0;
                op   = (cmd != 3'd7);
                ctl  = (cmd == 3'd6) ? 3'd1 : (cmd == 3'd7) ? 3'd0 : cmd;
            end
            8: rw = 1;
            9: begin srca = 1; srcb = 1; op = 1; rs = 2; pcw = 1; end
            default: ;
        endcase
        return {pcw, irw, mw, rw, adr, rs, srca, srcb, op, ctl};
    endfunction

    // Runs one instruction from FETCH, checking every cycle. af < 0 means random
    // ALUFlags each cycle. abort_at >= 0 pulses reset in that cycle of the sequence.
    task automatic run_instr(input logic [15:0] ins, input int af, input int abort_at);
        int q[$];
        logic [13:0] got;
        logic [13:0] exp;
        q.push_back(0);
        q.push_back(1);
        if (cond_true(ins[15:12], m_flags) && ins[11:10] != 2'b11) begin
            case (ins[11:10])
                2'b00: begin
                    q.push_back(ins[9] ? 7 : 6);
                    if (ins[8:6] != 3'd6) q.push_back(8);
                end
                2'b01: begin
                    q.push_back(2);
                    if (ins[5]) begin q.push_back(3); q.push_back(4); end
                    else q.push_back(5);
                end
                default: q.push_back(9);
            endcase
        end
        Instr = ins;
        for (int i = 0; i < q.size(); i++) begin
            ALUFlags = (af < 0) ? 4'($urandom_range(0, 15)) : 4'(af);
            #1;
            checks++;
            if (State !== 4'(q[i])) begin
                failures++;
                $display("FAIL state ins=%h cyc=%0d got=%0d exp=%0d", ins, i, State, q[i]);
            end
            got = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA,
                   ALUSrcB, ALUOp, ALUControl};
            exp = exp_out(q[i], ins);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL outputs ins=%h st=%0d got=%b exp=%b", ins, q[i], got, exp);
            end
            checks++;
            if (ImmSrc !== ins[11:10]) begin
                failures++;
                $display("FAIL immsrc ins=%h got=%b exp=%b", ins, ImmSrc, ins[11:10]);
            end
            checks++;
            if (Flags !== m_flags) begin
                failures++;
                $display("FAIL flags ins=%h cyc=%0d got=%b exp=%b", ins, i, Flags, m_flags);
            end
            if (i == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                m_flags = 4'b0000;
                checks++;
                if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
                    failures++;
                    $display("FAIL abort_strobes got=%b exp=0000",
                             {PCWrite, IRWrite, MemWrite, RegWrite});
                end
                checks++;
                if (State !== 4'd0 || Flags !== 4'd0) begin
                    failures++;
                    $display("FAIL abort_state got=%0d/%b exp=0/0000", State, Flags);
                end
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if ((q[i] == 6 || q[i] == 7) && (ins[5] || ins[8:6] == 3'd6)) m_flags = ALUFlags;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        Instr    = 16'hE000;
        ALUFlags = 4'b1111;
        m_flags  = 4'b0000;
        #12;
        checks++;
        if (State !== 4'd0 || Flags !== 4'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d/%b exp=0/0000", State, Flags);
        end
        checks++;
        if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000", {PCWrite, IRWrite, MemWrite, RegWrite});
        end
        checks++;
        if ({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ALUControl} !== 11'b0_10_1_10_1_000) begin
            failures++;
            $display("FAIL reset_selects got=%b exp=01011011000",
                     {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ALUControl});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_dp();
        run_instr(16'hE000, 0, -1);   // ADD AL register, S=0: flags must stay 0
        run_instr(16'hE180, 1, -1);   // CMP AL -> Z=1
        run_instr(16'h0000, -1, -1);  // ADD EQ executes
        run_instr(16'h1000, -1, -1);  // ADD NE annulled
        run_instr(16'hE3E0, 2, -1);   // MOVS immediate -> flags 0010
    endtask

    task automatic test_mem();
        run_instr(16'hE420, -1, -1);  // LDR
        run_instr(16'hE400, -1, -1);  // STR
    endtask

    task automatic test_branch();
        run_instr(16'hE180, 2, -1);   // CMP -> N=1 V=0
        run_instr(16'hB800, -1, -1);  // BLT taken
        run_instr(16'hE180, 6, -1);   // CMP -> N=1 V=1
        run_instr(16'hB800, -1, -1);  // BLT annulled
    endtask

    task automatic test_annul();
        run_instr(16'hEC00, -1, -1);  // Op=11
        run_instr(16'hF000, -1, -1);  // NV
    endtask

    task automatic test_abort();
        run_instr(16'hE180, 15, -1);  // nonzero flags before the abort
        run_instr(16'hE000, -1, 3);   // reset pulse during ALUWB
        run_instr(16'hE000, -1, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            run_instr(16'($urandom), -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_dp();
        test_mem();
        test_branch();
        test_annul();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control unit for the 8-bit CPU. It sequences every instruction through a Moore state machine and drives the ALU select inputs (ALUControl, ALUOp, ALUSrcA, ALUSrcB) and all datapath write strobes. It also consumes the ALU's combinational ALUFlags {CO,OVF,N,Z}, keeps them in an architectural flag register, and evaluates each instruction's condition field against that register.

## Interface
- No parameters. Instruction width is fixed at 16 bits.
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- Instr  in  16  current instruction-register contents
  - [15:12] Cond
  - [11:10] Op: 00 DP, 01 MEM, 10 BR, 11 undefined
  - [9] I: immediate operand
  - [8:6] Cmd
  - [5] S: set flags on DP; L: load on MEM
- ALUFlags  in  4  {CO,OVF,N,Z} from the ALU
- PCWrite, IRWrite, MemWrite, RegWrite  out  1 each  write strobes
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  1  ALU A operand: 0 = RegA, 1 = PC
- ALUSrcB  out  2  ALU B operand: 00 = RegB, 01 = ExtImm, 10 = constant 1
- ALUOp  out  1  1 = ALUControl operation, 0 = pass SrcB
- ALUControl  out  3  ALU operation code
- ImmSrc  out  2  equals Instr[11:10]; combinational
- Flags  out  4  flag register {C,V,N,Z}
- State  out  4  current state encoding, for debug and verification

## Operation
- **State encoding:**
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9
  - Codes 10–15 are illegal and go to FETCH.
- **Default outputs:** every output not listed for a state is 0.
- **Outputs per state:**
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=1, ALUControl=000, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=1, ALUControl=000. No strobes.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWR: AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, Cmd-mapped ALU controls.
  - EXECI: same as EXECR except ALUSrcB=01.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1.
- **Cmd mapping** (ALUOp=1 and ALUControl=Cmd unless noted):
  - 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 CLR
  - 110 CMP: ALUControl=001; flags always written; no ALUWB
  - 111 MOV: ALUOp=0, ALUControl=000
- **Transitions:**
  - FETCH→DECODE.
  - DECODE:
    - Condition fails, or Op=11 → FETCH (instruction annulled).
    - Otherwise Op=00 → EXECI if I=1, else EXECR.
    - Op=01 → MEMADR.
    - Op=10 → BRANCH.
  - MEMADR → MEMRD if L=1, else MEMWR.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXECR/EXECI → FETCH if Cmd=110, else ALUWB.
  - ALUWB → FETCH.
  - BRANCH → FETCH.
- **Conditions**, evaluated on Flags (the registered value) in DECODE:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL (always true); F NV (always false)
- **Flag register:**
  - Loads ALUFlags on the rising edge that ends EXECR or EXECI when S=1 or Cmd=110.
  - Holds in every other state.
  - MOV with S=1 loads the flags the ALU presents; the controller does not alter them.

## Timing
- **Reset:**
  - rst_n=0 forces State=FETCH and Flags=0000 immediately (asynchronous).
  - While rst_n=0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
  - All other outputs show their FETCH values during reset.
- **First cycle after release:** the first rising edge with rst_n=1 performs the first FETCH.
- **Reset mid-instruction:** aborts the instruction with no strobe. Flags clear and State returns to FETCH within the same cycle, with no clock edge needed.
- **Cycles per instruction:**
  - DP with writeback: 4
  - CMP: 3
  - LDR: 5
  - STR: 4
  - B: 3
  - Annulled (failed condition or Op=11): 2
- **Output timing:** all outputs are combinational from State and Instr. Strobes are asserted for exactly one cycle per visit to their state.
- **Condition timing:** the condition is judged against flags written by the previous instruction. A CMP immediately followed by a conditional instruction sees the new flags, because they are latched before the next DECODE.

## Test plan
- Reset, release, Instr=ADD AL S=0 register form (0xE000) → State sequence 0,1,6,8,0; RegWrite high only in cycle 4; ALUControl=000 in EXECR; Flags stay 0000.
- CMP AL (Cmd=110), ALUFlags=0001 during EXECR → Flags=0001 after the EXECR edge; ALUWB is skipped. Next instruction with Cond=EQ executes; with Cond=NE it goes DECODE→FETCH and no strobe fires.
- LDR (Op=01, L=1) → State 0,1,2,3,4,0; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB. STR (L=0) → 0,1,2,5,0 with MemWrite pulsed once.
- B with Cond=LT, Flags N=1 V=0 → BRANCH taken and PCWrite asserted in cycle 3. Same instruction with N=V → annulled after 2 cycles.
- Op=11 and Cond=1111 each → return to FETCH after DECODE. Pulse rst_n low during ALUWB → RegWrite drops immediately, State=0 and Flags=0000 without any clock edge.
- MOV immediate (Cmd=111, I=1) → EXECI with ALUOp=0 and ALUSrcB=01. With S=1 and ALUFlags=0010 → Flags=0010.
